oled_msg_sequencer: RTL and testbench

//   Sequences character writes into oled_controller (data_in/write_enable/buffer_full).

---
 rtl/oled_msg_sequencer_if.sv | 27 ++
 rtl/oled_msg_sequencer.sv | 153 +++++++++++++++
 tb/tb_oled_msg_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/oled_msg_sequencer_if.sv
// User-side bus of the OLED message sequencer: RAM load port, send control,
// controller backpressure and the write strobe toward oled_controller.
interface oled_msg_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;
    logic [ADDR_W:0]   msg_len;
    logic              start;
    logic              buffer_full;
    logic [7:0]        data_out;
    logic              write_enable;
    logic              ready;
    logic              busy;
    logic              done;

    modport slave (
        input  load_en, load_addr, load_data, msg_len, start, buffer_full,
        output data_out, write_enable, ready, busy, done
    );

    modport master (
        output load_en, load_addr, load_data, msg_len, start, buffer_full,
        input  data_out, write_enable, ready, busy, done
    );
endinterface

// File: rtl/oled_msg_sequencer.sv
// Streams a loaded message into oled_controller one byte per strobe,
// after a power-up delay, with backpressure and a fixed inter-write gap.
module oled_msg_sequencer #(
    parameter int CLK_FREQ          = 20_000_000,
    parameter int STARTUP_DELAY_CYC = CLK_FREQ / 2,
    parameter int ADDR_W            = 4,
    parameter int GAP_CYC           = 4
) (
    input logic                clk,
    input logic                reset,
    oled_msg_sequencer_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LEN_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(STARTUP_DELAY_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(STARTUP_DELAY_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_WAIT,
        S_WRITE,
        S_GAP,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       dout_q, dout_d;
    logic             we_q, we_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] len_clamp;

    logic [7:0] mem_q [DEPTH];

    assign len_clamp = (bus.msg_len > LEN_MAX) ? LEN_MAX : bus.msg_len;

    // Loads are frozen for the whole transfer so the streamed bytes stay stable.
    always_ff @(posedge clk) begin
        if (bus.load_en && !busy_q) begin
            mem_q[bus.load_addr] <= bus.load_data;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        len_d   = len_q;
        dout_d  = dout_q;
        we_d    = 1'b0;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_BOOT: begin
                if (cnt_q == DLY_LAST) begin
                    state_d = S_IDLE;
                    rdy_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (bus.start) begin
                    len_d  = len_clamp;
                    idx_d  = '0;
                    busy_d = 1'b1;
                    if (len_clamp == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.buffer_full) begin
                    state_d = S_WRITE;
                    we_d    = 1'b1;
                    dout_d  = mem_q[idx_q[ADDR_W-1:0]];
                end
            end
            S_WRITE: begin
                if (idx_q == len_q - LEN_ONE) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + LEN_ONE;
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_WAIT;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_BOOT;
            cnt_q   <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            dout_q  <= '0;
            we_q    <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            dout_q  <= dout_d;
            we_q    <= we_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.data_out     = dout_q;
    assign bus.write_enable = we_q;
    assign bus.ready        = rdy_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_oled_msg_sequencer.sv
// Bench for oled_msg_sequencer: timing-rule reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_oled_msg_sequencer;
    localparam int AW  = 4;
    localparam int DLY = 10;
    localparam int GAP = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    oled_msg_sequencer_if #(.ADDR_W(AW)) bus ();

    oled_msg_sequencer #(
        .CLK_FREQ         (20),
        .STARTUP_DELAY_CYC(DLY),
        .ADDR_W           (AW),
        .GAP_CYC          (GAP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: byte list plus "earliest cycle a WAIT may strobe"
    int         now = 0;
    int         boot_cyc = 0;
    int         wait_from = 0;
    logic [7:0] mram [16];
    logic [7:0] pend [$];
    logic [7:0] exp_data = 8'h00;
    logic       exp_we = 1'b0, exp_rdy = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;

    always @(posedge clk) begin
        logic nwe, ndone, nbusy;
        int   l;
        if (reset) begin
            exp_data = 8'h00;
            exp_we   = 1'b0;
            exp_rdy  = 1'b0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            boot_cyc = 0;
            pend.delete();
        end else begin
            nwe   = 1'b0;
            ndone = 1'b0;
            nbusy = exp_busy;
            if (bus.load_en && !exp_busy) mram[bus.load_addr] = bus.load_data;
            if (exp_done) nbusy = 1'b0;
            if (exp_we) begin
                if (pend.size() == 0) ndone = 1'b1;
                else wait_from = now + GAP + 1;
            end else if (pend.size() > 0 && now >= wait_from && !bus.buffer_full) begin
                nwe      = 1'b1;
                exp_data = pend.pop_front();
            end
            if (bus.start && exp_rdy && !exp_busy) begin
                l = (int'(bus.msg_len) > 16) ? 16 : int'(bus.msg_len);
                for (int i = 0; i < l; i++) pend.push_back(mram[i]);
                nbusy     = 1'b1;
                wait_from = now + 1;
                if (l == 0) ndone = 1'b1;
            end
            boot_cyc++;
            exp_rdy  = (boot_cyc >= DLY);
            exp_we   = nwe;
            exp_done = ndone;
            exp_busy = nbusy;
        end
        now++;
    end

    always @(negedge clk) begin
        chk("outputs",
            {20'h0, bus.write_enable, bus.data_out, bus.ready, bus.busy, bus.done},
            {20'h0, exp_we, exp_data, exp_rdy, exp_busy, exp_done});
    end

    logic [7:0] sq [$];
    int         sc [$];
    int         dc [$];

    always @(negedge clk) begin
        if (bus.write_enable) begin
            sq.push_back(bus.data_out);
            sc.push_back(now);
        end
        if (bus.done) dc.push_back(now);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        sq.delete();
        sc.delete();
        dc.delete();
    endtask

    task automatic load(input int a, input logic [7:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = AW'(a);
        bus.load_data = d;
        step();
        bus.load_en = 1'b0;
    endtask

    task automatic kick(input int len, output int t);
        bus.msg_len = (AW + 1)'(len);
        bus.start   = 1'b1;
        t           = now;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (!bus.done && k < budget) begin
            step();
            k++;
        end
        chk(name, {31'h0, bus.done}, 32'h1);
    endtask

    task automatic wait_strobes(input string name, input int n);
        int k = 0;
        while (sq.size() < n && k < 200) begin
            step();
            k++;
        end
        chk(name, sq.size(), n);
    endtask

    logic [7:0] hello [5] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};

    initial begin
        int rel, rdy_at, t, lowc;
        bus.load_en     = 1'b0;
        bus.load_addr   = '0;
        bus.load_data   = '0;
        bus.msg_len     = '0;
        bus.start       = 1'b0;
        bus.buffer_full = 1'b0;
        repeat (3) step();
        chk("reset_state",
            {27'h0, bus.write_enable, bus.ready, bus.busy, bus.done, |bus.data_out},
            32'h0);

        // 1: power-up delay, early starts ignored
        reset = 1'b0;
        rel    = now;
        rdy_at = -1;
        clear_log();
        bus.msg_len = 5'd3;
        while (now < rel + 14) begin
            bus.start = (now == rel + 3 || now == rel + 9);
            step();
            if (bus.ready && rdy_at < 0) rdy_at = now;
        end
        bus.start = 1'b0;
        chk("ready_rise", rdy_at - rel, DLY);
        chk("boot_no_we", sq.size(), 0);
        chk("boot_no_busy", {31'h0, bus.busy}, 32'h0);

        // 2: unthrottled "hello"
        for (int i = 0; i < 5; i++) load(i, hello[i]);
        clear_log();
        kick(5, t);
        wait_done("t2_done", 100);
        chk("t2_count", sq.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t2_byte%0d", i), sq[i], hello[i]);
        chk("t2_first_lat", sc[0] - t, 2);
        for (int i = 1; i < 5; i++) chk($sformatf("t2_period%0d", i), sc[i] - sc[i-1], 6);
        chk("t2_done_lat", dc[0] - sc[4], 1);
        step();

        // 3: backpressure before byte 2
        clear_log();
        kick(5, t);
        wait_strobes("t3_two", 2);
        bus.buffer_full = 1'b1;
        repeat (20) step();
        bus.buffer_full = 1'b0;
        lowc = now;
        wait_done("t3_done", 100);
        chk("t3_count", sq.size(), 5);
        chk("t3_b2_lat", sc[2] - lowc, 1);
        for (int i = 0; i < 5; i++) chk($sformatf("t3_byte%0d", i), sq[i], hello[i]);
        step();

        // 4: zero length and clamped length
        clear_log();
        kick(0, t);
        wait_done("t4_zero_done", 10);
        chk("t4_zero_lat", dc[0] - t, 1);
        chk("t4_zero_we", sq.size(), 0);
        step();
        for (int i = 0; i < 16; i++) load(i, 8'h30 + 8'(i));
        clear_log();
        kick(31, t);
        wait_done("t4_clamp_done", 300);
        chk("t4_clamp_count", sq.size(), 16);
        chk("t4_clamp_last", sq[15], 8'h3F);
        step();

        // 5: start and load while busy are dropped
        load(0, 8'h68);
        clear_log();
        kick(5, t);
        repeat (3) step();
        bus.start     = 1'b1;
        bus.load_en   = 1'b1;
        bus.load_addr = '0;
        bus.load_data = 8'h41;
        step();
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
        wait_done("t5_done", 100);
        chk("t5_count", sq.size(), 5);
        repeat (4) step();
        chk("t5_no_requeue", sq.size(), 5);
        clear_log();
        kick(1, t);
        wait_done("t5_resend_done", 20);
        chk("t5_resend_cnt", sq.size(), 1);
        chk("t5_ram0", sq[0], 8'h68);
        step();

        // 6: reset mid-send
        clear_log();
        kick(5, t);
        wait_strobes("t6_two", 2);
        reset = 1'b1;
        step();
        chk("t6_rst_out",
            {27'h0, bus.write_enable, bus.ready, bus.busy, bus.done, |bus.data_out},
            32'h0);
        reset  = 1'b0;
        rel    = now;
        rdy_at = -1;
        while (now < rel + 30) begin
            step();
            if (bus.ready && rdy_at < 0) rdy_at = now;
        end
        chk("t6_no_third", sq.size(), 2);
        chk("t6_ready_rise", rdy_at - rel, DLY);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
